sync_fifo_buf: RTL
==================

Name: sync_fifo_buf

Overview:
Single-clock, parametrised FIFO buffer. It combines the storage array with read/write pointers and occupancy tracking. Compared with the plain memory block, it adds a registered read port, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is the same-clock-domain buffer between producer and consumer datapaths.

Parameters:
DATA_SIZE, 8, width of each data word in bits
ADDR_SIZE, 4, pointer width; depth is 2**ADDR_SIZE words
AF_LEVEL, 12, o_almost_full asserts when count >= AF_LEVEL (range 1..2**ADDR_SIZE)
AE_LEVEL, 2, o_almost_empty asserts when count <= AE_LEVEL (range 0..2**ADDR_SIZE-1)

Ports:
i_clk  input  1  single clock; all logic on rising edge
i_rst  input  1  asynchronous, active-low reset
i_clr  input  1  synchronous flush; empties the FIFO and clears error flags
i_wr_en  input  1  write request
i_wr_data  input  DATA_SIZE  write data
i_rd_en  input  1  read request
o_rd_data  output  DATA_SIZE  registered read data
o_rd_valid  output  1  o_rd_data holds a word popped on the previous cycle
o_full  output  1  count == 2**ADDR_SIZE
o_empty  output  1  count == 0
o_almost_full  output  1  count >= AF_LEVEL
o_almost_empty  output  1  count <= AE_LEVEL
o_count  output  ADDR_SIZE+1  current occupancy
o_overflow  output  1  sticky: a write was attempted while full
o_underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (i_rst low, asynchronous): wr_ptr=0, rd_ptr=0, o_count=0, o_rd_data=0, o_rd_valid=0, o_overflow=0, o_underflow=0. As a result o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0. Memory contents are not reset.
- Pointers are ADDR_SIZE+1 bits wide. The MSB is the wrap bit. Full = (addr bits equal) AND (MSBs differ). Empty = pointers equal. o_count = wr_ptr - rd_ptr, modulo 2**(ADDR_SIZE+1).
- Write acceptance: wr_ok = i_wr_en & ~o_full. On wr_ok, mem[wr_ptr addr bits] <= i_wr_data and wr_ptr increments.
- Read acceptance: rd_ok = i_rd_en & ~o_empty. On rd_ok, o_rd_data <= mem[rd_ptr addr bits] and rd_ptr increments. Read latency is 1 cycle.
- o_rd_valid <= rd_ok every cycle. When o_rd_valid=0, o_rd_data holds its last value.
- Simultaneous read and write:
  - Non-full, non-empty: both are accepted and count is unchanged.
  - When empty: only the write is accepted. No read-through bypass is allowed; the written word becomes readable next cycle.
  - When full: only the read is accepted and the write is dropped.
- Pointer wrap: addresses wrap from 2**ADDR_SIZE-1 to 0 and the wrap bit toggles. No data is lost at the wrap.
- Status flags (o_full, o_empty, o_almost_full, o_almost_empty) are derived combinationally from the registered pointers. They reflect the state after the last clock edge, never the current-cycle requests.
- Overflow: o_overflow sets on i_wr_en & o_full and holds until reset or i_clr. The FIFO state is unaffected.
- Underflow: o_underflow sets on i_rd_en & o_empty and holds until reset or i_clr. The FIFO state is unaffected.
- i_clr: on the next edge, pointers are set to 0 and o_rd_valid, o_overflow and o_underflow are cleared. i_clr has priority over i_wr_en/i_rd_en in the same cycle, and those requests are ignored. o_rd_data is unchanged.
- Reset mid-operation: all contents are treated as discarded and the block returns immediately to the reset state. The first access after deassertion behaves as on an empty FIFO.
- Parameters outside the stated AF_LEVEL/AE_LEVEL ranges are illegal. The implementation flags them with an elaboration-time check.

Test Plan:
- Reset then idle -> o_empty=1, o_count=0, o_almost_empty=1, o_rd_valid=0, o_rd_data=0, both error flags 0.
- Write 0x01..0x10 (16 words, default params) -> o_almost_full rises when o_count=12, o_full=1 at 16. A 17th write with 0xFF sets o_overflow and leaves o_count=16.
- Read 16 words from full -> o_rd_data = 0x01..0x10 in order, each 1 cycle after its i_rd_en. o_empty=1 after the last read. One extra read sets o_underflow and gives o_rd_valid=0.
- Hold count at 8 with continuous simultaneous read+write for 40 cycles (pointers wrap twice) -> o_count stays 8, output data matches the write order, no error flags.
- Assert i_wr_en and i_rd_en together on an empty FIFO -> write accepted, o_rd_valid=0, o_count=1, o_underflow=1. Repeat on a full FIFO -> read accepted, o_count=15, o_overflow=1.
- With 5 words stored and both error flags set, assert i_clr together with i_wr_en -> next cycle o_count=0, o_empty=1, flags cleared, write ignored. Separately, async reset pulsed mid-burst -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Latency: a word written on edge N can be popped on edge N+1; read data is registered, 1 cycle after i_rd_en.
// Backpressure: writes are dropped while full and reads are ignored while empty; both cases set a sticky flag.
module sync_fifo_buf #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [DATA_SIZE-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [ADDR_SIZE:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Threshold constants sized to the count so the flag compares are width-matched.
  localparam logic [ADDR_SIZE:0] AF_L    = AF_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_L    = AE_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  // Threshold levels outside the meaningful range would leave a flag stuck; refuse to elaborate.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("sync_fifo_buf: AF_LEVEL must lie in 1..2**ADDR_SIZE");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("sync_fifo_buf: AE_LEVEL must lie in 0..2**ADDR_SIZE-1");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable with equal addresses.
  logic [ADDR_SIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE:0]   count;
  logic                 full;
  logic                 empty;
  logic                 wr_ok;
  logic                 rd_ok;

  assign wr_addr = wr_ptr_q[ADDR_SIZE-1:0];
  assign rd_addr = rd_ptr_q[ADDR_SIZE-1:0];

  // Status is purely a function of the registered pointers, never of this cycle's requests.
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    full  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]);
    empty = (wr_ptr_q == rd_ptr_q);
  end

  // Acceptance: a read on an empty FIFO is refused even when a write lands in the same cycle (no bypass).
  assign wr_ok = i_wr_en & ~full;
  assign rd_ok = i_rd_en & ~empty;

  // Next-state logic; a flush overrides any concurrent request and leaves the read data register alone.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem_q[rd_addr];
      end
      rd_valid_d = rd_ok;
      if (i_wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (i_rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control and read-port registers; reset discards all content by zeroing the pointers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge i_clk) begin
    if (!i_clr && wr_ok) begin
      mem_q[wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count >= AF_L);
  assign o_almost_empty = (count <= AE_L);
  assign o_count        = count;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule
